// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF packet-memory responder: load size codes,
// FSM state encoding and the size-to-byte-count helper.
package bpf_pkg;

    typedef enum logic [1:0] {
        SZ_W   = 2'b00,
        SZ_H   = 2'b01,
        SZ_B   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_LAST = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Number of bytes a load of the given size touches; 0 for the illegal code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_W:    return 3'd4;
            SZ_H:    return 3'd2;
            SZ_B:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/bpf_byte_ram.sv
// Simple dual-port DEPTH x 8 packet buffer: one write port, one registered
// read port with one cycle of latency. A read and write of the same byte in
// the same cycle returns the old byte.
module bpf_byte_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          iCLK,
    input  logic          iWE,
    input  logic [AW-1:0] iWADDR,
    input  logic [7:0]    iWDATA,
    input  logic          iRE,
    input  logic [AW-1:0] iRADDR,
    output logic [7:0]    oRDATA
);

    // NOTE: the array and read register carry no reset; clearing a RAM is not
    // something the hardware can do in one cycle, and nothing relies on it.
    logic [7:0] mem [DEPTH];

    // Write port and registered read port; the read samples the pre-write value.
    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem[iWADDR] <= iWDATA;
        end
        if (iRE) begin
            oRDATA <= mem[iRADDR];
        end
    end

endmodule

// File: rtl/bpf_pkt_mem.sv
// Memory responder for CPU packet loads (BPF LD/LDX ABS/IND). A request is
// bounds-checked against the stored packet length at accept; a legal load
// reads its bytes one per cycle in ascending order and returns them
// big-endian, zero-extended. A faulting load answers in the next cycle.
module bpf_pkt_mem
    import bpf_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iWR_EN,
    input  logic [AW-1:0] iWR_ADDR,
    input  logic [7:0]    iWR_DATA,
    input  logic          iLEN_WE,
    input  logic [AW:0]   iLEN,
    input  logic          iREQ,
    input  logic [31:0]   iADDR,
    input  logic [1:0]    iSIZE,
    output logic          oBUSY,
    output logic          oVALID,
    output logic [31:0]   oDATA,
    output logic          oFAULT
);

    state_e        state_q, state_d;
    logic [AW:0]   len_q;
    logic [AW-1:0] base_q;
    logic [1:0]    last_q;     // index of the final byte (n-1)
    logic [1:0]    cnt_q;      // index of the byte being read
    logic          fault_q;
    logic [31:0]   acc_q;      // big-endian assembly register
    logic          rd_pend_q;  // RAM read data lands this cycle

    logic          accept;
    logic [2:0]    req_n;
    logic [1:0]    req_last;
    logic [32:0]   req_end;
    logic          req_fault;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    // Accept-time decode and 33-bit bounds check (no wrap past 2^32).
    assign accept    = (state_q == ST_IDLE) && iREQ;
    assign req_n     = size_bytes(iSIZE);
    assign req_last  = (iSIZE == SZ_W) ? 2'd3 : ((iSIZE == SZ_H) ? 2'd1 : 2'd0);
    assign req_end   = {1'b0, iADDR} + {30'd0, req_n};
    assign req_fault = (iSIZE == SZ_ILL) || (req_end > {{(32 - AW){1'b0}}, len_q});

    bpf_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .iCLK   (iCLK),
        .iWE    (iWR_EN),
        .iWADDR (iWR_ADDR),
        .iWDATA (iWR_DATA),
        .iRE    (rd_en),
        .iRADDR (rd_addr),
        .oRDATA (rd_data)
    );

    // FSM state register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the values seen before the edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iREQ) state_d = req_fault ? ST_RESP : ST_READ;
            ST_READ: if (cnt_q == last_q) state_d = ST_LAST;
            ST_LAST: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, response and RAM read port.
    always_comb begin
        oBUSY   = (state_q != ST_IDLE);
        oVALID  = (state_q == ST_RESP);
        oFAULT  = 1'b0;
        oDATA   = 32'd0;
        rd_en   = (state_q == ST_READ);
        rd_addr = base_q + {{(AW - 2){1'b0}}, cnt_q};
        if (state_q == ST_RESP) begin
            oFAULT = fault_q;
            oDATA  = fault_q ? 32'd0 : acc_q;
        end
    end

    // Request latch, byte counter and big-endian assembly.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            base_q    <= '0;
            last_q    <= 2'd0;
            cnt_q     <= 2'd0;
            fault_q   <= 1'b0;
            acc_q     <= 32'd0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_en;
            if (accept) begin
                base_q  <= iADDR[AW-1:0];
                last_q  <= req_last;
                cnt_q   <= 2'd0;
                fault_q <= req_fault;
                acc_q   <= 32'd0;
            end else begin
                if (state_q == ST_READ) begin
                    cnt_q <= cnt_q + 2'd1;
                end
                if (rd_pend_q) begin
                    acc_q <= {acc_q[23:0], rd_data};
                end
            end
        end
    end

    // Stored packet length; an in-flight load keeps the verdict from accept.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            len_q <= '0;
        end else if (iLEN_WE) begin
            len_q <= iLEN;
        end
    end

endmodule

// File: tb/tb_bpf_pkt_mem.sv
// Self-checking bench for bpf_pkt_mem: a transaction-level model predicts
// busy/valid/fault/data every cycle, and directed loads pin literal results.
module tb_bpf_pkt_mem;

    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic          iCLK;
    logic          iRST_N;
    logic          iWR_EN;
    logic [AW-1:0] iWR_ADDR;
    logic [7:0]    iWR_DATA;
    logic          iLEN_WE;
    logic [AW:0]   iLEN;
    logic          iREQ;
    logic [31:0]   iADDR;
    logic [1:0]    iSIZE;
    logic          oBUSY;
    logic          oVALID;
    logic [31:0]   oDATA;
    logic          oFAULT;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    bpf_pkt_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iWR_EN   (iWR_EN),
        .iWR_ADDR (iWR_ADDR),
        .iWR_DATA (iWR_DATA),
        .iLEN_WE  (iLEN_WE),
        .iLEN     (iLEN),
        .iREQ     (iREQ),
        .iADDR    (iADDR),
        .iSIZE    (iSIZE),
        .oBUSY    (oBUSY),
        .oVALID   (oVALID),
        .oDATA    (oDATA),
        .oFAULT   (oFAULT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0]  m_mem [DEPTH];
    int          m_len = 0;
    int          m_age = 0;   // cycles since accept, 0 when idle
    int          m_lat = 0;   // cycle index of the response
    bit          m_fault = 0;
    logic [31:0] m_data = 0;
    logic [31:0] m_addr = 0;
    int          m_n = 0;

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            m_age = 0;
            m_len = 0;
        end else begin
            bit acc;
            longint unsigned e;
            acc = (m_age == 0) && (iREQ === 1'b1);
            if (m_age != 0) begin
                if (m_age == m_lat) m_age = 0;
                else m_age++;
            end
            if (acc) begin
                m_n     = (iSIZE == 2'b00) ? 4 : (iSIZE == 2'b01) ? 2 : (iSIZE == 2'b10) ? 1 : 0;
                e       = 64'(iADDR) + 64'(m_n);
                m_fault = (iSIZE == 2'b11) || (e > 64'(m_len));
                m_addr  = iADDR;
            end
            if (iWR_EN) m_mem[iWR_ADDR] = iWR_DATA;
            if (iLEN_WE) m_len = int'(iLEN);
            if (acc) begin
                m_data = 32'd0;
                if (!m_fault) begin
                    for (int i = 0; i < m_n; i++) begin
                        m_data = (m_data << 8) | 32'(m_mem[(int'(m_addr[AW-1:0]) + i) % DEPTH]);
                    end
                end
                m_age = 1;
                m_lat = m_fault ? 1 : m_n + 2;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge iCLK) begin
        bit exp_busy, exp_valid;
        exp_busy  = (m_age > 0);
        exp_valid = (m_age > 0) && (m_age == m_lat);
        check("cyc_busy", 32'(oBUSY), 32'(exp_busy));
        check("cyc_valid", 32'(oVALID), 32'(exp_valid));
        if (exp_valid) begin
            check("cyc_fault", 32'(oFAULT), 32'(m_fault));
            check("cyc_data", oDATA, m_data);
        end
        if (oVALID === 1'b1) vcount++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        iWR_EN = 1'b1; iWR_ADDR = AW'(a); iWR_DATA = d;
        tick();
        iWR_EN = 1'b0;
    endtask

    task automatic set_len(input int l);
        iLEN_WE = 1'b1; iLEN = (AW + 1)'(l);
        tick();
        iLEN_WE = 1'b0;
    endtask

    // Presents a request in an idle cycle; returns in cycle 1 after accept.
    task automatic start_load(input logic [31:0] a, input logic [1:0] s);
        iREQ = 1'b1; iADDR = a; iSIZE = s;
        tick();
        iREQ = 1'b0;
    endtask

    // Waits (bounded) for the response, starting in cycle first_k after accept.
    task automatic wait_resp(input string name, input int first_k, input logic [31:0] exp_data,
                             input bit exp_fault, input int exp_lat);
        bit found = 0;
        int lat = 0;
        for (int k = first_k; k <= 20 && !found; k++) begin
            @(negedge iCLK);
            if (oVALID === 1'b1) begin
                found = 1;
                lat   = k;
                check({name, "_data"}, oDATA, exp_data);
                check({name, "_fault"}, 32'(oFAULT), 32'(exp_fault));
            end
            tick();
        end
        check({name, "_seen"}, 32'(found), 32'd1);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] exp_data, input bit exp_fault, input int exp_lat);
        start_load(a, s);
        wait_resp(name, 1, exp_data, exp_fault, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        iRST_N = 1'b0; iWR_EN = 0; iWR_ADDR = 0; iWR_DATA = 0;
        iLEN_WE = 0; iLEN = 0; iREQ = 0; iADDR = 0; iSIZE = 0;
        repeat (2) tick();
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_valid", 32'(oVALID), 32'd0);
        check("rst_fault", 32'(oFAULT), 32'd0);
        check("rst_data", oDATA, 32'd0);
        iRST_N = 1'b1;
        tick();

        // Length 0 after reset: every load faults, latency 1.
        do_load("len0_b0", 32'd0, 2'b10, 32'd0, 1, 1);

        // Packet image: pattern bytes 0..63, IPv4-like header word at 12..15.
        for (int i = 0; i < 64; i++) host_write(i, 8'(i * 7 + 3));
        host_write(12, 8'h45); host_write(13, 8'h00);
        host_write(14, 8'h00); host_write(15, 8'h54);
        set_len(64);

        do_load("w12", 32'd12, 2'b00, 32'h45000054, 0, 6);
        do_load("h14", 32'd14, 2'b01, 32'h00000054, 0, 4);
        do_load("b12", 32'd12, 2'b10, 32'h00000045, 0, 3);
        do_load("w60", 32'd60, 2'b00, 32'hA7AEB5BC, 0, 6);
        do_load("w61", 32'd61, 2'b00, 32'd0, 1, 1);
        do_load("wwrap", 32'hFFFFFFFE, 2'b00, 32'd0, 1, 1);
        do_load("ill0", 32'd0, 2'b11, 32'd0, 1, 1);
        do_load("h63", 32'd63, 2'b01, 32'd0, 1, 1);
        do_load("b63", 32'd63, 2'b10, 32'h000000BC, 0, 3);
        do_load("hhi", 32'h00000810, 2'b01, 32'd0, 1, 1);

        // Host write to the byte being read in the same cycle returns old data.
        start_load(32'd20, 2'b10);
        iWR_EN = 1'b1; iWR_ADDR = AW'(20); iWR_DATA = 8'h11;
        tick();
        iWR_EN = 1'b0;
        wait_resp("rdw_old", 2, 32'h0000008F, 0, 3);
        do_load("rdw_new", 32'd20, 2'b10, 32'h00000011, 0, 3);

        // iREQ held through busy and RESP: exactly one response.
        v0 = vcount;
        iREQ = 1'b1; iADDR = 32'd12; iSIZE = 2'b00;
        repeat (7) tick();
        iREQ = 1'b0;
        repeat (4) tick();
        check("held_one_resp", 32'(vcount - v0), 32'd1);

        // Length cleared mid-load: the in-flight load keeps its accept verdict.
        start_load(32'd12, 2'b00);
        iLEN_WE = 1'b1; iLEN = '0;
        tick();
        iLEN_WE = 1'b0;
        wait_resp("lenwe_mid", 2, 32'h45000054, 0, 6);
        do_load("lenwe_after", 32'd12, 2'b10, 32'd0, 1, 1);
        set_len(64);

        // Reset during READ aborts with no response; RAM survives reset.
        v0 = vcount;
        start_load(32'd12, 2'b00);
        tick();
        iRST_N = 1'b0;
        #1;
        check("abort_busy", 32'(oBUSY), 32'd0);
        check("abort_valid", 32'(oVALID), 32'd0);
        check("abort_data", oDATA, 32'd0);
        repeat (2) tick();
        iRST_N = 1'b1;
        repeat (8) tick();
        check("abort_no_resp", 32'(vcount - v0), 32'd0);
        do_load("post_rst_len0", 32'd12, 2'b00, 32'd0, 1, 1);
        set_len(64);
        do_load("post_rst_w12", 32'd12, 2'b00, 32'h45000054, 0, 6);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
